// File: rtl/wb_commit_stage.sv
// Writeback / commit stage.
// Retired instructions from the memory stage enter an in-order commit queue of
// DEPTH entries. The head commits one instruction per cycle to the register
// file, or raises an exception or ERET redirect through the CP0 unit. CP0
// holds BadVAddr, Status, Cause and EPC.
//
// Handshake: the memory stage presents ms_to_ws_valid with its payload.
// ws_allowin reflects only the registered occupancy (count < DEPTH). A transfer
// happens on a rising edge where ms_to_ws_valid & ws_allowin & !ws_flush is
// true. A pop in the same cycle does not raise ws_allowin.
module wb_commit_stage #(
   parameter int              DW      = 32,
   parameter int              AW      = 5,
   parameter int              DEPTH   = 2,
   parameter logic [DW-1:0]   EXC_VEC = 32'hBFC00380
) (
   input  logic          clk,
   input  logic          reset,
   // memory-stage interface
   input  logic          ms_to_ws_valid,
   output logic          ws_allowin,
   input  logic [DW-1:0] ms_pc,
   input  logic          ms_gr_we,
   input  logic [AW-1:0] ms_dest,
   input  logic [DW-1:0] ms_result,
   input  logic [4:0]    ms_excode,
   input  logic [DW-1:0] ms_badvaddr,
   input  logic          ms_bd,
   input  logic          ms_eret,
   // commit control
   input  logic          commit_stall,
   input  logic          int_in,
   // register-file write port
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   // forwarding
   output logic [AW-1:0] WB_dest,
   output logic [DW-1:0] WB_dest_data,
   // redirect
   output logic          ws_flush,
   output logic [DW-1:0] ws_flush_pc,
   // CP0 access
   input  logic [4:0]    mfc0_raddr,
   output logic [DW-1:0] mfc0_rdata,
   input  logic          mtc0_we,
   input  logic [4:0]    mtc0_waddr,
   input  logic [DW-1:0] mtc0_wdata,
   // debug trace
   output logic [DW-1:0] debug_wb_pc,
   output logic [3:0]    debug_wb_rf_wen
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   // commit-queue storage, one field array per payload item
   logic [DW-1:0] r_q_pc     [DEPTH];
   logic          r_q_gr_we  [DEPTH];
   logic [AW-1:0] r_q_dest   [DEPTH];
   logic [DW-1:0] r_q_result [DEPTH];
   logic [4:0]    r_q_excode [DEPTH];
   logic [DW-1:0] r_q_badv   [DEPTH];
   logic          r_q_bd     [DEPTH];
   logic          r_q_eret   [DEPTH];

   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   // CP0 state
   logic [DW-1:0] r_epc;
   logic [DW-1:0] r_badvaddr;
   logic          r_status_exl;
   logic          r_status_ie;
   logic          r_cause_bd;
   logic [4:0]    r_cause_exc;

   // head-of-queue view
   logic          w_head_valid;
   logic [DW-1:0] w_head_pc;
   logic          w_head_gr_we;
   logic [AW-1:0] w_head_dest;
   logic [DW-1:0] w_head_result;
   logic [4:0]    w_head_excode;
   logic [DW-1:0] w_head_badv;
   logic          w_head_bd;
   logic          w_head_eret;

   // commit decisions
   logic          w_irq;
   logic          w_commit;
   logic          w_has_exc;
   logic          w_exc;
   logic          w_eret;
   logic          w_flush;
   logic [4:0]    w_code;
   logic          w_push;
   logic          w_pop;
   logic          w_badv_upd;

   assign w_head_valid  = (r_count != '0);
   assign w_head_pc     = r_q_pc[r_rd_ptr];
   assign w_head_gr_we  = r_q_gr_we[r_rd_ptr];
   assign w_head_dest   = r_q_dest[r_rd_ptr];
   assign w_head_result = r_q_result[r_rd_ptr];
   assign w_head_excode = r_q_excode[r_rd_ptr];
   assign w_head_badv   = r_q_badv[r_rd_ptr];
   assign w_head_bd     = r_q_bd[r_rd_ptr];
   assign w_head_eret   = r_q_eret[r_rd_ptr];

   // An interrupt is taken only at a commit and only outside exception level.
   assign w_irq      = int_in & r_status_ie & ~r_status_exl;
   assign w_commit   = w_head_valid & ~commit_stall;
   assign w_has_exc  = w_irq | (w_head_excode != 5'd0);
   assign w_exc      = w_commit & w_has_exc;
   assign w_eret     = w_commit & ~w_has_exc & w_head_eret;
   assign w_flush    = w_exc | w_eret;
   // An interrupt overrides the instruction's own exception code with 0.
   assign w_code     = w_irq ? 5'd0 : w_head_excode;
   assign w_badv_upd = (w_code == 5'd4) | (w_code == 5'd5);

   assign ws_allowin = (r_count < CW'(DEPTH));
   assign w_push     = ms_to_ws_valid & ws_allowin & ~w_flush;
   assign w_pop      = w_commit;

   // Commit outputs are driven combinationally from the head entry.
   assign rf_we           = w_commit & ~w_flush & w_head_gr_we;
   assign rf_waddr        = w_head_dest;
   assign rf_wdata        = w_head_result;
   assign WB_dest         = w_head_valid ? w_head_dest : '0;
   assign WB_dest_data    = w_head_result;
   assign ws_flush        = w_flush;
   assign ws_flush_pc     = w_exc ? EXC_VEC : r_epc;
   assign debug_wb_pc     = w_head_pc;
   assign debug_wb_rf_wen = {4{rf_we}};

   // Write the incoming payload into the tail slot on an accepted push.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_wr_ptr]     <= ms_pc;
         r_q_gr_we[r_wr_ptr]  <= ms_gr_we;
         r_q_dest[r_wr_ptr]   <= ms_dest;
         r_q_result[r_wr_ptr] <= ms_result;
         r_q_excode[r_wr_ptr] <= ms_excode;
         r_q_badv[r_wr_ptr]   <= ms_badvaddr;
         r_q_bd[r_wr_ptr]     <= ms_bd;
         r_q_eret[r_wr_ptr]   <= ms_eret;
      end
   end

   // Pointer and occupancy bookkeeping; a flush empties the whole queue.
   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // CP0 update: mtc0 first, so exception/ERET updates below take priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_epc        <= '0;
         r_badvaddr   <= '0;
         r_status_exl <= 1'b0;
         r_status_ie  <= 1'b0;
         r_cause_bd   <= 1'b0;
         r_cause_exc  <= 5'd0;
      end else begin
         if (mtc0_we && (mtc0_waddr == CP0_STATUS)) begin
            r_status_exl <= mtc0_wdata[1];
            r_status_ie  <= mtc0_wdata[0];
         end
         if (mtc0_we && (mtc0_waddr == CP0_EPC)) begin
            r_epc <= mtc0_wdata;
         end
         if (w_exc) begin
            r_cause_exc  <= w_code;
            r_status_exl <= 1'b1;
            // A nested exception keeps the original EPC and BD.
            if (!r_status_exl) begin
               r_epc      <= w_head_bd ? (w_head_pc - DW'(4)) : w_head_pc;
               r_cause_bd <= w_head_bd;
            end
            if (w_badv_upd) begin
               r_badvaddr <= w_head_badv;
            end
         end else if (w_eret) begin
            r_status_exl <= 1'b0;
         end
      end
   end

   // CP0 read mux returns the current (pre-update) register values.
   always_comb begin
      mfc0_rdata = '0;
      case (mfc0_raddr)
         CP0_BADVADDR: mfc0_rdata = r_badvaddr;
         CP0_STATUS:   mfc0_rdata = {{(DW-2){1'b0}}, r_status_exl, r_status_ie};
         CP0_CAUSE:    mfc0_rdata = {r_cause_bd, {(DW-8){1'b0}}, r_cause_exc, 2'b00};
         CP0_EPC:      mfc0_rdata = r_epc;
         default:      mfc0_rdata = '0;
      endcase
   end

endmodule
